// File: rtl/io_user_buttons.sv
// io_user_buttons: synchronise and debounce push-buttons and switches, and derive per-button press/release/long/toggle events
module io_user_buttons #(
  parameter int P_BTN_NUM  = 4,
  parameter int P_SW_NUM   = 4,
  parameter int P_CE_DIV   = 100000,
  parameter int P_DEBOUNCE = 20,
  parameter int P_LONG     = 1000
) (
  input  logic                 I_CLK_100MHZ,
  input  logic                 I_RST_N,
  input  logic [P_BTN_NUM-1:0] I_BTN,
  input  logic [P_SW_NUM-1:0]  I_SW,
  output logic [P_BTN_NUM-1:0] O_BTN_LEVEL,
  output logic [P_BTN_NUM-1:0] O_BTN_PRESS,
  output logic [P_BTN_NUM-1:0] O_BTN_RELEASE,
  output logic [P_BTN_NUM-1:0] O_BTN_LONG,
  output logic [P_BTN_NUM-1:0] O_BTN_TOGGLE,
  output logic [P_SW_NUM-1:0]  O_SW_LEVEL,
  output logic                 O_CE_TICK
);
  localparam int N  = P_BTN_NUM + P_SW_NUM;
  localparam int CW = $clog2(P_CE_DIV + 1);
  localparam int DW = $clog2(P_DEBOUNCE + 1);
  localparam int LW = $clog2(P_LONG + 1);
  logic [CW-1:0]        ce_cnt;
  logic                 tick;
  logic [N-1:0]         sync_a, sync_b, stable;
  logic [DW-1:0]        db_cnt [N];
  logic [LW-1:0]        hold [P_BTN_NUM];
  logic [P_BTN_NUM-1:0] btn_q, at_long, long_q;
  assign tick        = ce_cnt == CW'(P_CE_DIV - 1);
  assign O_CE_TICK   = tick;
  assign O_BTN_LEVEL = stable[P_BTN_NUM-1:0];
  assign O_SW_LEVEL  = stable[N-1:P_BTN_NUM];
  always_comb begin
    at_long = '0;
    for (int i = 0; i < P_BTN_NUM; i++) at_long[i] = hold[i] == LW'(P_LONG);
  end
  always_ff @(posedge I_CLK_100MHZ or negedge I_RST_N) begin
    if (!I_RST_N) begin
      ce_cnt        <= '0;
      sync_a        <= '0;
      sync_b        <= '0;
      stable        <= '0;
      btn_q         <= '0;
      long_q        <= '0;
      O_BTN_PRESS   <= '0;
      O_BTN_RELEASE <= '0;
      O_BTN_LONG    <= '0;
      O_BTN_TOGGLE  <= '0;
      for (int i = 0; i < N; i++) db_cnt[i] <= '0;
      for (int i = 0; i < P_BTN_NUM; i++) hold[i] <= '0;
    end else begin
      ce_cnt <= tick ? '0 : ce_cnt + 1'b1;
      sync_a <= {I_SW, I_BTN};
      sync_b <= sync_a;
      // a new level is only accepted after P_DEBOUNCE consecutive disagreeing ticks
      for (int i = 0; i < N; i++) begin
        if (tick) begin
          if (sync_b[i] == stable[i]) db_cnt[i] <= '0;
          else if (db_cnt[i] == DW'(P_DEBOUNCE - 1)) begin
            stable[i] <= sync_b[i];
            db_cnt[i] <= '0;
          end else db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      btn_q         <= O_BTN_LEVEL;
      long_q        <= at_long;
      O_BTN_PRESS   <= O_BTN_LEVEL & ~btn_q;
      O_BTN_RELEASE <= ~O_BTN_LEVEL & btn_q;
      O_BTN_LONG    <= at_long & ~long_q;
      O_BTN_TOGGLE  <= O_BTN_TOGGLE ^ (O_BTN_LEVEL & ~btn_q);
      // hold counter saturates so the long event fires once per press
      for (int i = 0; i < P_BTN_NUM; i++) begin
        if (!stable[i]) hold[i] <= '0;
        else if (tick && !at_long[i]) hold[i] <= hold[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_io_user_buttons.sv
// tb_io_user_buttons: directed checks of debounce, event pulses, long press, toggle and reset behaviour
module tb_io_user_buttons;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] btn = '0, sw = '0;
  logic [3:0] level, press, release_p, long_p, toggle, sw_level;
  logic ce_tick;
  logic [24:0] all_out;
  int n_vec = 0, n_err = 0, cyc = 0;
  int press_n[4], rel_n[4], long_n[4], press_at[4], long_at[4], lvl_rise[4], sw_rise[4];
  logic [3:0] lvl_q = '0, sw_q = '0;
  logic seen1 = 1'b0;
  int last_tick = -1, gap = 0;
  int t, t2, r, pn, ln, rn;

  io_user_buttons #(.P_BTN_NUM(4), .P_SW_NUM(4), .P_CE_DIV(10), .P_DEBOUNCE(4), .P_LONG(8)) dut (
    .I_CLK_100MHZ(clk), .I_RST_N(rst_n), .I_BTN(btn), .I_SW(sw),
    .O_BTN_LEVEL(level), .O_BTN_PRESS(press), .O_BTN_RELEASE(release_p), .O_BTN_LONG(long_p),
    .O_BTN_TOGGLE(toggle), .O_SW_LEVEL(sw_level), .O_CE_TICK(ce_tick)
  );

  assign all_out = {level, press, release_p, long_p, toggle, sw_level, ce_tick};
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin press_n[i]++; press_at[i] = cyc; end
      if (release_p[i]) rel_n[i]++;
      if (long_p[i]) begin long_n[i]++; long_at[i] = cyc; end
      if (level[i] && !lvl_q[i]) lvl_rise[i] = cyc;
      if (sw_level[i] && !sw_q[i]) sw_rise[i] = cyc;
    end
    if (level[1]) seen1 = 1'b1;
    lvl_q = level;
    sw_q  = sw_level;
    if (ce_tick) begin
      if (last_tick >= 0) gap = cyc - last_tick;
      last_tick = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int tt);
    logic found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      found = ce_tick;
    end
    chk("tick_wait", 32'(found), 1);
    tt = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    chk("reset_outputs", 32'(all_out), 0);
    rst_n = 1'b1;
    r = cyc;
    step(8);
    chk("no_tick_before_9", 32'(ce_tick), 0);
    step(1);
    chk("first_tick_at_9", 32'(cyc - r), 9);
    chk("first_tick_high", 32'(ce_tick), 1);
    wait_tick(t);
    wait_tick(t2);
    chk("tick_period", 32'(t2 - t), 10);
    // clean press on button 0
    wait_tick(t);
    btn[0] = 1'b1;
    step(45);
    chk("clean_level_at", 32'(lvl_rise[0]), 32'(t + 41));
    chk("clean_press_at", 32'(press_at[0]), 32'(t + 42));
    chk("clean_press_cnt", 32'(press_n[0]), 1);
    chk("clean_level", 32'(level), 32'h1);
    chk("clean_toggle", 32'(toggle), 32'h1);
    chk("clean_other_press", 32'(press_n[1] + press_n[2] + press_n[3]), 0);
    btn[0] = 1'b0;
    step(50);
    chk("clean_release_cnt", 32'(rel_n[0]), 1);
    chk("clean_no_long", 32'(long_n[0]), 0);
    chk("clean_level_low", 32'(level), 0);
    // two 3-tick glitches on button 1 separated by one quiet tick
    wait_tick(t);
    btn[1] = 1'b1;
    step(30);
    btn[1] = 1'b0;
    step(10);
    btn[1] = 1'b1;
    step(30);
    btn[1] = 1'b0;
    step(50);
    chk("glitch_no_press", 32'(press_n[1]), 0);
    chk("glitch_no_level", 32'(seen1), 0);
    // long press on button 2
    wait_tick(t);
    btn[2] = 1'b1;
    step(200);
    chk("long_press_cnt", 32'(press_n[2]), 1);
    chk("long_cnt", 32'(long_n[2]), 1);
    chk("long_after_level", 32'(long_at[2] - lvl_rise[2]), 81);
    chk("long_at_abs", 32'(long_at[2]), 32'(t + 122));
    btn[2] = 1'b0;
    step(60);
    chk("long_release_cnt", 32'(rel_n[2]), 1);
    chk("long_no_second", 32'(long_n[2]), 1);
    chk("long_toggle", 32'(toggle), 32'h5);
    // toggle sequence on button 3
    for (int k = 0; k < 3; k++) begin
      btn[3] = 1'b1;
      step(50);
      chk("toggle_seq", 32'(toggle[3]), 32'((k + 1) % 2));
      btn[3] = 1'b0;
      step(50);
    end
    chk("toggle_presses", 32'(press_n[3]), 3);
    chk("toggle_releases", 32'(rel_n[3]), 3);
    // simultaneous buttons and switches
    btn = 4'b1111;
    sw  = 4'b1111;
    step(50);
    chk("sim_press_cnt", 32'({press_n[0], press_n[1], press_n[2], press_n[3]} == {32'd2, 32'd1, 32'd2, 32'd4}), 1);
    for (int k = 1; k < 4; k++) chk("sim_press_same_clk", 32'(press_at[k]), 32'(press_at[0]));
    for (int k = 0; k < 4; k++) chk("sim_sw_same_tick", 32'(sw_rise[k]), 32'(lvl_rise[0]));
    chk("sim_sw_level", 32'(sw_level), 32'hF);
    chk("sim_toggle", 32'(toggle), 32'h2);
    btn = '0;
    sw  = '0;
    step(50);
    chk("sim_release", 32'({rel_n[0], rel_n[1], rel_n[2], rel_n[3]} == {32'd2, 32'd1, 32'd2, 32'd4}), 1);
    chk("sim_sw_low", 32'(sw_level), 0);
    chk("sim_no_long", 32'(long_n[0] + long_n[1] + long_n[3]), 0);
    // reset while button 0 is held
    wait_tick(t);
    btn[0] = 1'b1;
    step(60);
    chk("mid_press_before_reset", 32'(press_n[0]), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", 32'(all_out), 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("mid_reset_hold", 32'(all_out), 0);
    end
    pn = press_n[0];
    ln = long_n[0];
    rn = rel_n[0];
    rst_n = 1'b1;
    r = cyc;
    step(130);
    chk("mid_press_again_at", 32'(press_at[0]), 32'(r + 41));
    chk("mid_press_again_cnt", 32'(press_n[0] - pn), 1);
    chk("mid_long_at", 32'(long_at[0]), 32'(r + 121));
    chk("mid_long_cnt", 32'(long_n[0] - ln), 1);
    chk("mid_no_release", 32'(rel_n[0] - rn), 0);
    chk("mid_toggle", 32'(toggle), 32'h1);
    chk("tick_gap_final", 32'(gap), 10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
